// File: rtl/match_pkg.sv
// Shared opcode constants and matcher state encoding, also imported by the side processor.
package match_pkg;

  localparam int unsigned OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_ADD  = 3'd1;
  localparam logic [OPC_W-1:0] OP_EXEC = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    EXEC  = 3'd3,
    RESID = 3'd4
  } st_t;

endpackage

// File: rtl/match_engine.sv
// Multi-level price-time matcher: walks opposite-side levels for a taker ADD, emits
// EXEC + fill per crossed level, posts any remainder as an ADD; other ops pass through.
module match_engine
  import match_pkg::*;
#(
  parameter int unsigned PRICE_W    = 48,
  parameter int unsigned QTY_W      = 32,
  parameter int unsigned MAX_LEVELS = 4,
  parameter int unsigned LVL_IDX_W  = (MAX_LEVELS > 1) ? $clog2(MAX_LEVELS) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,

  input  logic                 in_v,
  output logic                 in_r,
  input  logic [OPC_W-1:0]     in_opcode,
  input  logic                 in_side,
  input  logic [PRICE_W-1:0]   in_price,
  input  logic [QTY_W-1:0]     in_qty,

  output logic                 lvl_req_v,
  output logic                 lvl_side,
  output logic [LVL_IDX_W-1:0] lvl_idx,
  input  logic                 lvl_rsp_exists,
  input  logic [PRICE_W-1:0]   lvl_rsp_price,
  input  logic [QTY_W-1:0]     lvl_rsp_qty,

  output logic                 busy,

  output logic                 sp_v,
  input  logic                 sp_r,
  output logic [OPC_W-1:0]     sp_opcode,
  output logic                 sp_side,
  output logic [PRICE_W-1:0]   sp_price,
  output logic [QTY_W-1:0]     sp_qty,

  output logic                 tfill_v,
  input  logic                 tfill_r,
  output logic                 tfill_side,
  output logic [PRICE_W-1:0]   tfill_price,
  output logic [QTY_W-1:0]     tfill_qty,
  output logic                 tfill_last
);

  localparam logic [LVL_IDX_W-1:0] LAST_IDX = LVL_IDX_W'(MAX_LEVELS - 1);

  st_t                  state;
  logic                 side_q;
  logic [PRICE_W-1:0]   px_q;
  logic [QTY_W-1:0]     rem_q;
  logic [QTY_W-1:0]     fq_q;
  logic [LVL_IDX_W-1:0] idx_q;

  logic                 sp_v_q;
  logic [OPC_W-1:0]     sp_op_q;
  logic                 sp_side_q;
  logic [PRICE_W-1:0]   sp_price_q;
  logic [QTY_W-1:0]     sp_qty_q;

  logic                 pass_c;
  logic                 crosses_c;
  logic [QTY_W-1:0]     fill_qty_c;
  logic [QTY_W-1:0]     rem_after_c;

  // Level crossing test and fill size against the level presented in WAIT
  always_comb begin
    fill_qty_c  = (lvl_rsp_qty < rem_q) ? lvl_rsp_qty : rem_q;
    rem_after_c = rem_q - fq_q;
    crosses_c   = lvl_rsp_exists && (lvl_rsp_qty != '0) &&
                  ((side_q == 1'b0) ? (px_q >= lvl_rsp_price) : (px_q <= lvl_rsp_price));
  end

  // Non-ADD ops in IDLE bypass the matcher with zero latency
  always_comb begin
    pass_c    = rstn && (state == IDLE) && (in_opcode != OP_ADD);
    in_r      = rstn && (state == IDLE) && ((in_opcode == OP_ADD) || sp_r);
    sp_v      = pass_c ? in_v      : sp_v_q;
    sp_opcode = pass_c ? in_opcode : sp_op_q;
    sp_side   = pass_c ? in_side   : sp_side_q;
    sp_price  = pass_c ? in_price  : sp_price_q;
    sp_qty    = pass_c ? in_qty    : sp_qty_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      side_q      <= 1'b0;
      px_q        <= '0;
      rem_q       <= '0;
      fq_q        <= '0;
      idx_q       <= '0;
      busy        <= 1'b0;
      lvl_req_v   <= 1'b0;
      lvl_side    <= 1'b0;
      lvl_idx     <= '0;
      sp_v_q      <= 1'b0;
      sp_op_q     <= '0;
      sp_side_q   <= 1'b0;
      sp_price_q  <= '0;
      sp_qty_q    <= '0;
      tfill_v     <= 1'b0;
      tfill_side  <= 1'b0;
      tfill_price <= '0;
      tfill_qty   <= '0;
      tfill_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_v && (in_opcode == OP_ADD)) begin
            side_q <= in_side;
            px_q   <= in_price;
            rem_q  <= in_qty;
            idx_q  <= '0;
            // Zero-quantity ADDs are dropped without touching the book
            if (in_qty != '0) begin
              state     <= REQ;
              busy      <= 1'b1;
              lvl_req_v <= 1'b1;
              lvl_side  <= ~in_side;
              lvl_idx   <= '0;
            end
          end
        end

        REQ: begin
          lvl_req_v <= 1'b0;
          state     <= WAIT;
        end

        WAIT: begin
          if (crosses_c) begin
            fq_q        <= fill_qty_c;
            state       <= EXEC;
            sp_v_q      <= 1'b1;
            sp_op_q     <= OP_EXEC;
            sp_side_q   <= ~side_q;
            sp_price_q  <= lvl_rsp_price;
            sp_qty_q    <= fill_qty_c;
            tfill_v     <= 1'b1;
            tfill_side  <= ~side_q;
            tfill_price <= lvl_rsp_price;
            tfill_qty   <= fill_qty_c;
            tfill_last  <= (fill_qty_c == rem_q) || (idx_q == LAST_IDX);
          end else begin
            state      <= RESID;
            sp_v_q     <= 1'b1;
            sp_op_q    <= OP_ADD;
            sp_side_q  <= side_q;
            sp_price_q <= px_q;
            sp_qty_q   <= rem_q;
          end
        end

        EXEC: begin
          // EXEC and its fill retire together so the side processor and trade log stay aligned
          if (sp_r && tfill_r) begin
            sp_v_q     <= 1'b0;
            tfill_v    <= 1'b0;
            tfill_last <= 1'b0;
            rem_q      <= rem_after_c;
            if (rem_after_c == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (idx_q == LAST_IDX) begin
              state      <= RESID;
              sp_v_q     <= 1'b1;
              sp_op_q    <= OP_ADD;
              sp_side_q  <= side_q;
              sp_price_q <= px_q;
              sp_qty_q   <= rem_after_c;
            end else begin
              idx_q     <= idx_q + LVL_IDX_W'(1);
              state     <= REQ;
              lvl_req_v <= 1'b1;
              lvl_idx   <= idx_q + LVL_IDX_W'(1);
            end
          end
        end

        RESID: begin
          if (sp_r) begin
            sp_v_q <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_engine.sv
// Randomized bench for match_engine with a level-walk reference model and per-cycle output monitor.
module tb_match_engine;

  localparam int unsigned PW = 48;
  localparam int unsigned QW = 32;
  localparam int unsigned ML = 4;
  localparam int unsigned IW = 2;
  localparam logic [2:0]  C_ADD  = 3'd1;
  localparam logic [2:0]  C_EXEC = 3'd4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_v;
  logic          in_r;
  logic [2:0]    in_opcode;
  logic          in_side;
  logic [PW-1:0] in_price;
  logic [QW-1:0] in_qty;
  logic          lvl_req_v;
  logic          lvl_side;
  logic [IW-1:0] lvl_idx;
  logic          lvl_rsp_exists;
  logic [PW-1:0] lvl_rsp_price;
  logic [QW-1:0] lvl_rsp_qty;
  logic          busy;
  logic          sp_v;
  logic          sp_r;
  logic [2:0]    sp_opcode;
  logic          sp_side;
  logic [PW-1:0] sp_price;
  logic [QW-1:0] sp_qty;
  logic          tfill_v;
  logic          tfill_r;
  logic          tfill_side;
  logic [PW-1:0] tfill_price;
  logic [QW-1:0] tfill_qty;
  logic          tfill_last;

  match_engine #(.PRICE_W(PW), .QTY_W(QW), .MAX_LEVELS(ML), .LVL_IDX_W(IW)) dut (
    .clk(clk), .rstn(rstn),
    .in_v(in_v), .in_r(in_r), .in_opcode(in_opcode), .in_side(in_side),
    .in_price(in_price), .in_qty(in_qty),
    .lvl_req_v(lvl_req_v), .lvl_side(lvl_side), .lvl_idx(lvl_idx),
    .lvl_rsp_exists(lvl_rsp_exists), .lvl_rsp_price(lvl_rsp_price), .lvl_rsp_qty(lvl_rsp_qty),
    .busy(busy),
    .sp_v(sp_v), .sp_r(sp_r), .sp_opcode(sp_opcode), .sp_side(sp_side),
    .sp_price(sp_price), .sp_qty(sp_qty),
    .tfill_v(tfill_v), .tfill_r(tfill_r), .tfill_side(tfill_side),
    .tfill_price(tfill_price), .tfill_qty(tfill_qty), .tfill_last(tfill_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    op;
    logic          side;
    logic [PW-1:0] px;
    logic [QW-1:0] qty;
    logic          fill;
    logic          last;
  } ev_t;

  ev_t           exp_q[$];
  int            vec = 0;
  int            errs = 0;
  int            lvl_req_cnt = 0;
  int            rdy_mode = 0;
  logic          exp_maker = 1'b0;
  logic          book_ex  [ML];
  logic [PW-1:0] book_px  [ML];
  logic [QW-1:0] book_qty [ML];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the frozen book level by level from the taker's point of view
  task automatic build_exp(input logic s, input logic [PW-1:0] p, input logic [QW-1:0] q);
    longint unsigned rem;
    longint unsigned fq;
    bit cr;
    ev_t e;
    rem = q;
    if (q == 0) return;
    for (int i = 0; i < ML; i++) begin
      cr = book_ex[i] && (book_qty[i] != 0) && (s == 1'b0 ? (p >= book_px[i]) : (p <= book_px[i]));
      if (!cr) break;
      fq = (rem < book_qty[i]) ? rem : longint'(book_qty[i]);
      rem = rem - fq;
      e.op = C_EXEC; e.side = ~s; e.px = book_px[i]; e.qty = QW'(fq);
      e.fill = 1'b1; e.last = (rem == 0) || (i == ML - 1);
      exp_q.push_back(e);
      if (rem == 0) break;
    end
    if (rem > 0) begin
      e.op = C_ADD; e.side = s; e.px = p; e.qty = QW'(rem); e.fill = 1'b0; e.last = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic set_level(input int i, input logic ex, input int px, input int qty);
    book_ex[i] = ex; book_px[i] = PW'(px); book_qty[i] = QW'(qty);
  endtask

  task automatic clear_book();
    for (int i = 0; i < ML; i++) set_level(i, 1'b0, 0, 0);
  endtask

  // Level source: registered lookup, response valid the cycle after the strobe
  initial begin
    logic          req_s;
    logic [IW-1:0] idx_s;
    lvl_rsp_exists = 1'b0; lvl_rsp_price = '0; lvl_rsp_qty = '0;
    forever begin
      @(negedge clk);
      req_s = lvl_req_v; idx_s = lvl_idx;
      @(posedge clk); #1;
      if (req_s) begin
        lvl_rsp_exists = book_ex[idx_s]; lvl_rsp_price = book_px[idx_s]; lvl_rsp_qty = book_qty[idx_s];
      end else begin
        lvl_rsp_exists = 1'b0; lvl_rsp_price = PW'($urandom); lvl_rsp_qty = QW'($urandom);
      end
    end
  end

  // Downstream readiness: 0 always ready, 1 random backpressure, 2 driven by the test
  initial begin
    sp_r = 1'b1; tfill_r = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) begin
        sp_r = 1'b1; tfill_r = 1'b1;
      end else if (rdy_mode == 1) begin
        sp_r = ($urandom_range(0, 3) != 0); tfill_r = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Output monitor: every completed transfer is checked against the model queue
  logic [255:0] snap_prev;
  logic         prev_pend = 1'b0;
  always @(negedge clk) begin
    logic [255:0] snap;
    logic         xfer;
    ev_t          e;
    snap = 256'({sp_v, sp_opcode, sp_side, sp_price, sp_qty,
                 tfill_v, tfill_side, tfill_price, tfill_qty, tfill_last});
    if (!rstn) begin
      prev_pend = 1'b0;
    end else begin
      if (busy) chk("in_r_while_busy", 256'(in_r), 256'(0));
      if (tfill_v) chk("fill_paired_with_sp", 256'(sp_v), 256'(1));
      if (prev_pend) chk("hold_stable", snap, snap_prev);
      if (lvl_req_v) begin
        lvl_req_cnt++;
        chk("lvl_side", 256'(lvl_side), 256'(exp_maker));
      end
      xfer = sp_v && sp_r && (!tfill_v || tfill_r);
      if (xfer) begin
        if (exp_q.size() == 0) begin
          vec++; errs++;
          $display("FAIL unexpected_output: got op %0d side %0d px %0d qty %0d, required none",
                   sp_opcode, sp_side, sp_price, sp_qty);
        end else begin
          e = exp_q.pop_front();
          chk("sp_opcode", 256'(sp_opcode), 256'(e.op));
          chk("sp_side", 256'(sp_side), 256'(e.side));
          chk("sp_price", 256'(sp_price), 256'(e.px));
          chk("sp_qty", 256'(sp_qty), 256'(e.qty));
          chk("tfill_v", 256'(tfill_v), 256'(e.fill));
          if (e.fill) begin
            chk("tfill_side", 256'(tfill_side), 256'(e.side));
            chk("tfill_price", 256'(tfill_price), 256'(e.px));
            chk("tfill_qty", 256'(tfill_qty), 256'(e.qty));
            chk("tfill_last", 256'(tfill_last), 256'(e.last));
          end
        end
      end
      prev_pend = sp_v && !xfer;
    end
    snap_prev = snap;
  end

  task automatic send_op(input logic [2:0] op, input logic s, input int px, input int qty);
    bit ok;
    ok = 1'b0;
    in_opcode = op; in_side = s; in_price = PW'(px); in_qty = QW'(qty); in_v = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_r) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      vec++; errs++;
      $display("FAIL in_handshake_timeout: got in_r 0, required 1");
    end
    @(posedge clk); #1;
    in_v = 1'b0;
  endtask

  task automatic issue_add(input logic s, input int px, input int qty);
    exp_maker = ~s;
    build_exp(s, PW'(px), QW'(qty));
    send_op(C_ADD, s, px, qty);
  endtask

  task automatic issue_pass(input logic [2:0] op, input logic s, input int px, input int qty);
    ev_t e;
    e.op = op; e.side = s; e.px = PW'(px); e.qty = QW'(qty); e.fill = 1'b0; e.last = 1'b0;
    exp_q.push_back(e);
    send_op(op, s, px, qty);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && !sp_v && exp_q.size() == 0) begin done = 1'b1; break; end
    end
    if (!done) begin
      vec++; errs++;
      $display("FAIL order_timeout: got busy %0d with %0d outputs outstanding, required idle", busy, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int c0;
    logic s;
    int   px, qty;
    rstn = 1'b0; in_v = 1'b0; in_opcode = '0; in_side = 1'b0; in_price = '0; in_qty = '0;
    clear_book();
    #1;
    chk("reset_in_r", 256'(in_r), 256'(0));
    chk("reset_busy", 256'(busy), 256'(0));
    chk("reset_sp_v", 256'(sp_v), 256'(0));
    chk("reset_tfill_v", 256'(tfill_v), 256'(0));
    chk("reset_lvl_req_v", 256'(lvl_req_v), 256'(0));
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    // Passthrough: same-cycle sp_v, fields copied, no level lookups
    c0 = lvl_req_cnt;
    exp_q.push_back('{op: 3'd3, side: 1'b1, px: PW'(123), qty: QW'(10), fill: 1'b0, last: 1'b0});
    in_opcode = 3'd3; in_side = 1'b1; in_price = PW'(123); in_qty = QW'(10); in_v = 1'b1;
    #1;
    chk("pass_sp_v", 256'(sp_v), 256'(1));
    chk("pass_sp_qty", 256'(sp_qty), 256'(10));
    chk("pass_in_r", 256'(in_r), 256'(1));
    @(posedge clk); #1 in_v = 1'b0;
    wait_idle();
    chk("pass_no_lvl_req", 256'(lvl_req_cnt - c0), 256'(0));

    // Single full fill at level 0, with request/response/output latency
    clear_book(); set_level(0, 1'b1, 99, 80);
    c0 = lvl_req_cnt;
    exp_maker = 1'b1;
    build_exp(1'b0, PW'(100), QW'(50));
    chk("model_single_n", 256'(exp_q.size()), 256'(1));
    chk("model_single_ev", 256'({exp_q[0].op, exp_q[0].side, exp_q[0].px, exp_q[0].qty, exp_q[0].last}),
        256'({C_EXEC, 1'b1, PW'(99), QW'(50), 1'b1}));
    send_op(C_ADD, 1'b0, 100, 50);
    @(negedge clk);
    chk("lat_c1_req", 256'(lvl_req_v), 256'(1));
    chk("lat_c1_sp_v", 256'(sp_v), 256'(0));
    @(negedge clk);
    chk("lat_c2_req", 256'(lvl_req_v), 256'(0));
    @(negedge clk);
    chk("lat_c3_sp_v", 256'(sp_v), 256'(1));
    chk("lat_c3_tfill_last", 256'(tfill_last), 256'(1));
    wait_idle();
    chk("single_lvl_reqs", 256'(lvl_req_cnt - c0), 256'(1));

    // Two partial fills then a residual at the taker price
    clear_book(); set_level(0, 1'b1, 99, 30); set_level(1, 1'b1, 100, 30); set_level(2, 1'b1, 102, 50);
    c0 = lvl_req_cnt;
    exp_maker = 1'b1;
    build_exp(1'b0, PW'(101), QW'(100));
    chk("model_multi_n", 256'(exp_q.size()), 256'(3));
    chk("model_multi_e1", 256'({exp_q[1].op, exp_q[1].px, exp_q[1].qty, exp_q[1].last}),
        256'({C_EXEC, PW'(100), QW'(30), 1'b0}));
    chk("model_multi_r", 256'({exp_q[2].op, exp_q[2].side, exp_q[2].px, exp_q[2].qty}),
        256'({C_ADD, 1'b0, PW'(101), QW'(40)}));
    send_op(C_ADD, 1'b0, 101, 100);
    wait_idle();
    chk("multi_lvl_reqs", 256'(lvl_req_cnt - c0), 256'(3));

    // Level cap: every level crosses, the last allowed one carries tfill_last
    clear_book();
    for (int i = 0; i < ML; i++) set_level(i, 1'b1, 95 - i, 10);
    exp_maker = 1'b0;
    build_exp(1'b1, PW'(90), QW'(100));
    chk("model_cap_n", 256'(exp_q.size()), 256'(ML + 1));
    chk("model_cap_last", 256'({exp_q[ML-2].last, exp_q[ML-1].last}), 256'(2'b01));
    chk("model_cap_resid", 256'(exp_q[ML].qty), 256'(100 - 10 * ML));
    send_op(C_ADD, 1'b1, 90, 100);
    wait_idle();

    // Zero-quantity ADD is dropped silently
    c0 = lvl_req_cnt;
    issue_add(1'b0, 100, 0);
    wait_idle();
    chk("zero_qty_no_req", 256'(lvl_req_cnt - c0), 256'(0));

    // Fill side stalled while the side processor is ready
    clear_book(); set_level(0, 1'b1, 99, 80);
    rdy_mode = 2; sp_r = 1'b1; tfill_r = 1'b0;
    issue_add(1'b0, 100, 50);
    for (int i = 0; i < 10 && !sp_v; i++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("stall_sp_v", 256'(sp_v), 256'(1));
      chk("stall_tfill_v", 256'(tfill_v), 256'(1));
      chk("stall_pending", 256'(exp_q.size()), 256'(1));
    end
    @(posedge clk); #1 tfill_r = 1'b1;
    wait_idle();
    rdy_mode = 0;

    // Reset while waiting on a level response aborts the order
    clear_book(); set_level(0, 1'b1, 99, 80);
    issue_add(1'b0, 100, 50);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("rst_sp_v", 256'(sp_v), 256'(0));
    chk("rst_tfill_v", 256'(tfill_v), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_lvl_req_v", 256'(lvl_req_v), 256'(0));
    chk("rst_in_r", 256'(in_r), 256'(0));
    chk("rst_sp_qty", 256'(sp_qty), 256'(0));
    exp_q.delete();
    @(posedge clk); #1 rstn = 1'b1;
    issue_pass(3'd2, 1'b0, 77, 5);
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_quiet", 256'({sp_v, tfill_v, busy}), 256'(0));
    end
    wait_idle();

    // Randomized orders and passthrough ops under random backpressure
    rdy_mode = 1;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [2:0] op;
        op = 3'($urandom_range(0, 7));
        if (op == C_ADD) op = 3'd3;
        issue_pass(op, 1'($urandom_range(0, 1)), int'($urandom_range(0, 500)), int'($urandom_range(0, 100)));
      end else begin
        s   = 1'($urandom_range(0, 1));
        px  = int'($urandom_range(94, 106));
        qty = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 80));
        for (int i = 0; i < ML; i++)
          set_level(i, ($urandom_range(0, 9) != 0),
                     (s == 1'b0) ? 96 + 2 * i + int'($urandom_range(0, 1))
                                 : 104 - 2 * i - int'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40)));
        issue_add(s, px, qty);
      end
      wait_idle();
    end
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog");
  end

endmodule
